cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one downstream memory port (req/wr/addrOK/dataOK protocol) between the instruction cache and the data cache.
- Grants one requester at a time with 2-way round-robin. Forwards that requester's address, write data and strobes, and routes the addrOK/dataOK handshakes back to it.
- Sits between the L1 caches and the L2/bus bridge.
- Read transactions complete on dataOK. Write (write-through) transactions complete on addrOK.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, read-line width returned by memory.
- WDATA_W, 32, write data width (dcache only).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req  in  1  icache request (read only); held until i_addrOK
i_addr  in  ADDR_W  icache line address
i_addrOK  out  1  icache request accepted
i_dataOK  out  1  icache read data valid
d_req  in  1  dcache request; held until d_addrOK, and may stay high until d_dataOK
d_wr  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  dcache address
d_wstrb  in  4  byte strobes
d_wdata  in  WDATA_W  write data
d_addrOK  out  1  dcache request accepted
d_dataOK  out  1  dcache read data valid
rdata  out  LINE_W  mem_rdata broadcast to both caches; valid only with the owner's dataOK
mem_req  out  1  downstream request
mem_wr  out  1  downstream write flag
mem_addr  out  ADDR_W  downstream address
mem_wstrb  out  4  downstream strobes
mem_wdata  out  WDATA_W  downstream write data
mem_addrOK  in  1  downstream accepted address/data
mem_dataOK  in  1  downstream read data valid
mem_rdata  in  LINE_W  downstream read data
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ADDR, RDATA. Registers: state, owner_q (0 = icache, 1 = dcache), last_q (last granted requester).
- Reset (async, rst = 1):
  - state = IDLE, owner_q = 0, last_q = 1, so icache wins the first tie.
  - All outputs 0 while in reset, including mem_req and every addrOK/dataOK.
- IDLE:
  - Grant rule:
    - Only i_req high: owner_q <= 0.
    - Only d_req high: owner_q <= 1.
    - Both high: owner_q <= ~last_q.
  - On any grant: state <= ADDR.
  - mem_req = 0.
  - This gives a 1-cycle arbitration bubble.
- ADDR:
  - mem_req = 1.
  - mem_wr = owner_q ? d_wr : 0.
  - mem_addr, mem_wstrb, mem_wdata muxed from the owner. Icache drives wstrb = 0 and wdata = 0.
  - On mem_addrOK, the owner's addrOK pulses combinationally in the same cycle and last_q <= owner_q.
    - If the transaction is a write: state <= IDLE.
    - If it is a read: state <= RDATA.
  - Without mem_addrOK: hold ADDR with outputs stable.
- RDATA:
  - mem_req = 0.
  - Requester req levels are ignored; the dcache keeps d_req high while waiting.
  - On mem_dataOK: the owner's dataOK pulses the same cycle, rdata = mem_rdata, state <= IDLE.
- Latencies:
  - Minimum read: request to addrOK is 1 cycle, plus memory latency to dataOK.
  - Minimum write: request to addrOK is 1 cycle.
  - A requester whose req is still high in the cycle after completion is re-arbitrated normally.
- The non-owner never sees addrOK or dataOK.
- mem_addrOK in IDLE/RDATA and mem_dataOK in IDLE/ADDR are ignored.
- Requester dropping req while in ADDR is a protocol violation. The arbiter still forwards mem_req = 1 until addrOK, and the bench flags it.
- Fairness: under continuous requests from both caches, grants alternate i, d, i, d...
- Reset asserted mid-ADDR or mid-RDATA: immediate return to IDLE with all outputs 0. An outstanding downstream read is abandoned, and the downstream is reset with the same rst.

Decomposition:
- Shared package cache_mem_pkg:
  - State encoding (IDLE = 2'd0, ADDR = 2'd1, RDATA = 2'd2).
  - Owner encoding (OWN_I = 1'b0, OWN_D = 1'b1).
  - Default widths.
- One sub-module rr_arbiter2:
  - Inputs: req[1:0], last.
  - Outputs: one-hot grant and grant index.
  - Combinational; last_q stays in the parent.

Test Plan:
- Icache read alone: i_req = 1, addr 0x1C000040; mem_addrOK 1 cycle after mem_req, mem_dataOK 4 cycles later with rdata 0xA5..A5 -> i_addrOK and i_dataOK each pulse once, rdata matches, d_* handshakes stay 0, busy falls the cycle after dataOK.
- Simultaneous i_req and d_req (read) right after reset: icache granted first, dcache next, then icache again while both stay high -> mem_addr alternates 0x1000/0x2000/0x1000.
- Dcache write: d_wr = 1, wstrb 4'b0011, wdata 0xDEADBEEF -> mem_wr = 1 with matching strobes/data; d_addrOK on mem_addrOK; no RDATA state; busy low the next cycle.
- Back-pressure: mem_addrOK delayed 5 cycles -> mem_req, mem_addr, mem_wdata stable all 5 cycles; exactly one d_addrOK.
- Spurious mem_dataOK in IDLE, and mem_addrOK during RDATA -> no dataOK/addrOK to either cache; state unchanged.
- rst pulsed during RDATA -> outputs 0 asynchronously; after release a new i_req is granted in 1 cycle with icache tie priority.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared encodings and default widths for the L1-to-memory arbiter.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int ADDR_W_DEF  = 32;
    localparam int LINE_W_DEF  = 128;
    localparam int WDATA_W_DEF = 32;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = req[1];
        if (req == 2'b11) begin
            grant_idx = ~last;
        end
        grant = 2'b00;
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one downstream memory port between icache (index 0) and dcache (index 1).
// Writes retire on addrOK; reads wait in RDATA for dataOK.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int WDATA_W = WDATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_addrOK,
    output logic               i_dataOK,
    input  logic               d_req,
    input  logic               d_wr,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [3:0]         d_wstrb,
    input  logic [WDATA_W-1:0] d_wdata,
    output logic               d_addrOK,
    output logic               d_dataOK,
    output logic [LINE_W-1:0]  rdata,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [3:0]         mem_wstrb,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic               mem_addrOK,
    input  logic               mem_dataOK,
    input  logic [LINE_W-1:0]  mem_rdata,
    output logic               busy
);

    state_t     state;
    logic       owner_q;
    logic       last_q;
    logic [1:0] grant;
    logic       grant_idx;
    logic       in_addr;
    logic       in_rdata;
    logic       is_write;

    rr_arbiter2 u_rr (
        .req       ({d_req, i_req}),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_addr  = (state == ADDR);
    assign in_rdata = (state == RDATA);
    assign is_write = (owner_q == OWN_D) && d_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner_q <= grant_idx;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_addrOK) begin
                        last_q <= owner_q;
                        state  <= is_write ? IDLE : RDATA;
                    end
                end
                RDATA: begin
                    if (mem_dataOK) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream bus is only driven while a request is being presented.
    assign mem_req = in_addr;
    assign mem_wr  = in_addr && is_write;

    always_comb begin
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (in_addr) begin
            if (owner_q == OWN_D) begin
                mem_addr  = d_addr;
                mem_wstrb = d_wstrb;
                mem_wdata = d_wdata;
            end else begin
                mem_addr = i_addr;
            end
        end
    end

    assign i_addrOK = in_addr  && mem_addrOK && (owner_q == OWN_I);
    assign d_addrOK = in_addr  && mem_addrOK && (owner_q == OWN_D);
    assign i_dataOK = in_rdata && mem_dataOK && (owner_q == OWN_I);
    assign d_dataOK = in_rdata && mem_dataOK && (owner_q == OWN_D);
    assign rdata    = (in_rdata && mem_dataOK) ? mem_rdata : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized two-requester traffic against a transaction-level scoreboard of the arbiter.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, i_addrOK, i_dataOK;
    logic [31:0]  i_addr;
    logic         d_req, d_wr, d_addrOK, d_dataOK;
    logic [31:0]  d_addr, d_wdata;
    logic [3:0]   d_wstrb;
    logic [127:0] rdata;
    logic         mem_req, mem_wr, mem_addrOK, mem_dataOK;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [127:0] mem_rdata;
    logic         busy;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } item_t;

    item_t qi[$];
    item_t qd[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    slow_read = 1'b0;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addrOK(i_addrOK), .i_dataOK(i_dataOK),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addrOK(d_addrOK), .d_dataOK(d_dataOK), .rdata(rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addrOK(mem_addrOK), .mem_dataOK(mem_dataOK),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Contents of the downstream memory: every line is a fixed function of its address.
    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a ^ 32'hA5A5A5A5, ~a, a + 32'd1, {a[15:0], a[31:16]}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream memory: random address back-pressure, random read latency, plus
    // stray addrOK whenever no request is presented and stray dataOK when no read is owed.
    initial begin
        int          rd_cnt;
        int          wait_cnt;
        bit          started;
        logic [31:0] rd_addr;
        rd_cnt = 0; wait_cnt = 0; started = 0; rd_addr = '0;
        mem_addrOK = 1'b0; mem_dataOK = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_addrOK = 1'b0;
            mem_dataOK = 1'b0;
            if (rst) begin
                rd_cnt = 0; started = 0;
                mem_addrOK = 1'b1; mem_dataOK = 1'b1; mem_rdata = '1;
                continue;
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_dataOK = 1'b1;
                    mem_rdata  = line_of(rd_addr);
                end
            end else if ($urandom_range(0, 5) == 0) begin
                mem_dataOK = 1'b1;
                mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_req) begin
                if (!started) begin
                    started  = 1;
                    wait_cnt = $urandom_range(0, 5);
                end
                if (wait_cnt == 0) begin
                    mem_addrOK = 1'b1;
                    started    = 0;
                    if (!mem_wr) begin
                        rd_cnt  = slow_read ? 12 : $urandom_range(1, 5);
                        rd_addr = mem_addr;
                    end
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                mem_addrOK = 1'b1;
            end
        end
    end

    // Scoreboard: tracks the transaction in flight and predicts the owner from the
    // request levels seen in the arbitration cycle and the last granted requester.
    bit m_last = 1'b1, m_owner = 1'b0;
    bit in_addr = 0, awaiting = 0, grant_due = 0, pi = 0, pd = 0;

    always @(negedge clk) begin
        item_t    it;
        bit       done;
        bit       empty;
        logic [3:0] hs_exp;
        if (rst) begin
            qi.delete(); qd.delete();
            m_last = 1'b1; in_addr = 0; awaiting = 0; grant_due = 0;
        end else begin
            done = 0;
            it   = '0;
            if (grant_due) begin
                grant_due = 0;
                check("grant_latency", mem_req, 1'b1);
                m_owner = (pi && pd) ? !m_last : pd;
                in_addr = 1;
            end else if (!in_addr) begin
                check("mem_req_quiet", mem_req, 1'b0);
            end
            empty = m_owner ? (qd.size() == 0) : (qi.size() == 0);
            if ((in_addr || awaiting) && !empty) it = m_owner ? qd[0] : qi[0];
            if (in_addr) begin
                if (empty) begin
                    n_vec++; n_err++;
                    $display("FAIL grant_owner: granted %0d with nothing pending, required a pending requester", m_owner);
                end
                check("mem_fields", {mem_wr, mem_addr, mem_wstrb, mem_wdata}, it);
                check("owner_req_held", m_owner ? d_req : i_req, 1'b1);
            end
            check("busy", busy, in_addr || awaiting);
            hs_exp = {in_addr && mem_addrOK && !m_owner, in_addr && mem_addrOK && m_owner,
                      awaiting && mem_dataOK && !m_owner, awaiting && mem_dataOK && m_owner};
            check("handshakes", {i_addrOK, d_addrOK, i_dataOK, d_dataOK}, hs_exp);
            if (in_addr && mem_addrOK) begin
                m_last  = m_owner;
                in_addr = 0;
                if (it.wr) done = 1;
                else awaiting = 1;
            end else if (awaiting && mem_dataOK) begin
                check("rdata", rdata, line_of(it.addr));
                awaiting = 0;
                done = 1;
            end
            if (done && !empty) begin
                if (m_owner) void'(qd.pop_front());
                else void'(qi.pop_front());
            end
            if (!in_addr && !awaiting && !done && (i_req || d_req)) begin
                grant_due = 1;
                pi = i_req;
                pd = d_req;
            end
        end
    end

    task automatic wait_data(input bit is_d);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(is_d ? d_dataOK : i_dataOK) && n < 400);
        if (n >= 400) begin
            n_vec++; n_err++;
            $display("FAIL %s_dataOK_timeout: none within 400 cycles, required one", is_d ? "d" : "i");
        end
    endtask

    task automatic do_req(input bit is_d, input bit wr, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wdata, input bit hold);
        item_t it;
        int    n;
        bit    rd;
        rd       = !(is_d && wr);
        it.wr    = is_d && wr;
        it.addr  = addr;
        it.strb  = is_d ? strb : 4'h0;
        it.wdata = is_d ? wdata : 32'h0;
        @(posedge clk); #1;
        if (is_d) begin
            qd.push_back(it);
            d_wr = wr; d_addr = addr; d_wstrb = strb; d_wdata = wdata; d_req = 1'b1;
        end else begin
            qi.push_back(it);
            i_addr = addr; i_req = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(is_d ? d_addrOK : i_addrOK) && n < 400);
        if (n >= 400) begin
            n_vec++; n_err++;
            $display("FAIL %s_addrOK_timeout: none within 400 cycles, required one", is_d ? "d" : "i");
        end
        if (rd && hold) wait_data(is_d);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0;
        else i_req = 1'b0;
        if (rd && !hold) wait_data(is_d);
    endtask

    task automatic icache_run();
        logic [31:0] a;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = (k % 5 == 0) ? 32'h1C000040 : ($urandom & 32'hFFFF_FFF0);
            do_req(1'b0, 1'b0, a, 4'h0, 32'h0, 1'b0);
        end
    endtask

    task automatic dcache_run();
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if (k == 0)
                do_req(1'b1, 1'b1, 32'h0000_3000, 4'b0011, 32'hDEADBEEF, 1'b0);
            else
                do_req(1'b1, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                       4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h1C000040;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_handshakes", {i_addrOK, i_dataOK, d_addrOK, d_dataOK}, 4'h0);
        check("reset_mem_ctrl", {mem_req, mem_wr, busy}, 3'h0);
        check("reset_mem_bus", {mem_addr, mem_wstrb, mem_wdata}, 68'h0);
        check("reset_rdata", rdata, 128'h0);
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;

        fork
            icache_run();
            dcache_run();
        join

        // Abandon a read in flight with an asynchronous reset.
        slow_read = 1'b1;
        @(posedge clk); #1;
        i_addr = 32'h1C000040; i_req = 1'b1;
        qi.push_back('{wr: 1'b0, addr: 32'h1C000040, strb: 4'h0, wdata: 32'h0});
        n = 0;
        do begin @(negedge clk); n++; end while (!i_addrOK && n < 100);
        if (n >= 100) begin
            n_vec++; n_err++;
            $display("FAIL rst_setup_addrOK: none within 100 cycles, required one");
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        @(posedge clk); #1;
        check("rdata_wait_busy", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrd_reset_ctrl", {busy, mem_req, mem_wr, i_addrOK, i_dataOK, d_addrOK, d_dataOK}, 7'h0);
        check("midrd_reset_bus", {mem_addr, mem_wstrb, mem_wdata}, 68'h0);
        check("midrd_reset_rdata", rdata, 128'h0);
        repeat (2) @(posedge clk);
        slow_read = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;

        // Tie right after reset: icache first, then alternation.
        fork
            begin
                do_req(1'b0, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
                do_req(1'b0, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
            end
            do_req(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, 1'b1);
        join

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
